// File: rtl/cb_fir_sequencer.sv
// rtl/cb_fir_sequencer.sv - circular-buffer frame sequencer for the FIR datapath
// One write plus an NTAPW-word backwards read sweep per accepted sample, with MAC strobes delayed to match RAM read latency.
module cb_fir_sequencer #(
  parameter int NTAPW  = 1024,
  parameter int RD_LAT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] xin,
  input  logic        xin_valid,
  output logic        xin_ready,
  output logic [17:0] ram_din,
  output logic        ram_wen,
  output logic [11:0] ram_addr,
  output logic [11:0] coef_addr,
  output logic        mac_valid,
  output logic        mac_first,
  output logic        mac_last,
  output logic [1:0]  mac_phase,
  output logic        done,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  localparam logic [12:0] LAST_IDX = 13'(NTAPW - 1);

  state_t             state;
  logic [13:0]        scnt;
  logic [13:0]        scnt_inc;
  logic [11:0]        w;
  logic [12:0]        idx;
  logic [12:0]        idx_nxt;
  logic               iss_v;
  logic               iss_f;
  logic               iss_l;
  logic [RD_LAT-1:0]  pv;
  logic [RD_LAT-1:0]  pf;
  logic [RD_LAT-1:0]  pl;

  assign scnt_inc  = scnt + 14'd1;
  assign idx_nxt   = idx + 13'd1;
  assign mac_valid = pv[RD_LAT-1];
  assign mac_first = pf[RD_LAT-1];
  assign mac_last  = pl[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      scnt      <= '0;
      w         <= '0;
      idx       <= '0;
      iss_v     <= 1'b0;
      iss_f     <= 1'b0;
      iss_l     <= 1'b0;
      pv        <= '0;
      pf        <= '0;
      pl        <= '0;
      xin_ready <= 1'b1;
      ram_din   <= '0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      coef_addr <= '0;
      mac_phase <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ram_wen <= 1'b0;
      done    <= 1'b0;
      if (xin_valid && !xin_ready)
        overrun <= 1'b1;

      // Issue flags ride alongside ram_addr, then age RD_LAT cycles to meet rdout.
      pv <= RD_LAT'({pv, iss_v});
      pf <= RD_LAT'({pf, iss_f});
      pl <= RD_LAT'({pl, iss_l});

      case (state)
        S_IDLE: begin
          if (xin_valid) begin
            ram_din   <= xin;
            ram_wen   <= 1'b1;
            xin_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          scnt      <= scnt_inc;
          w         <= scnt_inc[13:2];
          mac_phase <= scnt[1:0];
          ram_addr  <= scnt_inc[13:2];
          coef_addr <= '0;
          idx       <= '0;
          iss_v     <= 1'b1;
          iss_f     <= 1'b1;
          iss_l     <= (LAST_IDX == 13'd0);
          state     <= S_READ;
        end
        S_READ: begin
          if (idx == LAST_IDX) begin
            iss_v <= 1'b0;
            iss_f <= 1'b0;
            iss_l <= 1'b0;
            state <= S_DRAIN;
          end else begin
            idx       <= idx_nxt;
            ram_addr  <= w - idx_nxt[11:0];
            coef_addr <= idx_nxt[11:0];
            iss_f     <= 1'b0;
            iss_l     <= (idx_nxt == LAST_IDX);
          end
        end
        S_DRAIN: begin
          // mac_last is always seen here: it trails the final READ cycle by RD_LAT >= 1.
          if (mac_last) begin
            done      <= 1'b1;
            xin_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cb_fir_sequencer.md
Name: cb_fir_sequencer

Overview:
- Frame controller for the 16k-sample circular-buffer RAM used by the FIR datapath (18-bit samples in; 72-bit, 4-sample word reads out).
- Per accepted input sample:
  - writes the sample into the buffer;
  - sweeps NTAPW read word addresses from the newest word backwards, with matching coefficient addresses;
  - emits MAC strobes aligned to the registered RAM read data;
  - then returns to idle.
- Sits between the sample source and the RAM/MAC datapath.

Parameters:
- NTAPW, 1024, 4-sample words read per output; legal range 1..4096.
- RD_LAT, 3, cycles from ram_addr driven to rdout valid (address register + RAM + output register); legal range 1..8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- xin  in  18  input sample.
- xin_valid  in  1  xin valid this cycle.
- xin_ready  out  1  sequencer idle; sample accepted when xin_valid & xin_ready.
- ram_din  out  18  sample to RAM.
- ram_wen  out  1  one-cycle RAM write strobe.
- ram_addr  out  12  read word address.
- coef_addr  out  12  coefficient word index, aligned with ram_addr.
- mac_valid  out  1  rdout valid for MAC this cycle.
- mac_first  out  1  first word of frame (with mac_valid).
- mac_last  out  1  last word of frame (with mac_valid).
- mac_phase  out  2  sample index[1:0] of newest sample; constant for the frame.
- done  out  1  one-cycle pulse, frame complete.
- busy  out  1  not in IDLE.
- overrun  out  1  sticky: sample offered while busy.

Behaviour:
- **Reset:** clock and reset as named; reset is synchronous, active-low. When reset==0 at a rising edge:
  - state=IDLE;
  - sample counter scnt[13:0]=0;
  - all outputs 0 except xin_ready=1;
  - the read-issue delay pipeline is cleared.
- **Output timing:** all outputs are registered.
- **State machine:** IDLE -> WRITE -> READ -> DRAIN -> IDLE.
- **IDLE:**
  - xin_ready=1.
  - On accept in cycle T: latch xin and go to WRITE.
- **WRITE (cycle T+1):**
  - ram_wen=1, ram_din=latched sample.
  - scnt <= scnt+1 (mod 16384).
  - Latch w = new word index (scnt+1)[13:2] and mac_phase = scnt[1:0], i.e. the index of the written sample.
  - Go to READ.
- **READ (cycles T+2 .. T+1+NTAPW):**
  - Index i counts 0..NTAPW-1.
  - ram_addr = (w - i) mod 4096; coef_addr = i.
  - Issue strobe, first flag (i==0) and last flag (i==NTAPW-1) enter an RD_LAT-deep shift pipeline.
  - After i==NTAPW-1, go to DRAIN.
  - ram_addr and coef_addr hold their last value outside READ.
- **Pipeline outputs:** mac_valid, mac_first and mac_last are the pipeline outputs. mac_valid therefore asserts at cycles T+2+RD_LAT .. T+1+NTAPW+RD_LAT.
  - NTAPW=1: mac_first and mac_last assert in the same cycle.
- **DRAIN:**
  - Wait until mac_last has been output.
  - The following cycle: done=1, xin_ready=1, state=IDLE. That is cycle T+2+NTAPW+RD_LAT.
  - A new sample may be accepted in that same cycle.
- **busy:** equals !xin_ready.
- **Overrun:**
  - xin_valid=1 while xin_ready=0 sets overrun.
  - The sample is dropped; scnt is unchanged.
  - overrun is cleared only by reset.
- **Address wrap:**
  - scnt wraps 16383->0.
  - Read address subtraction is modulo 4096 (12-bit wrap): w=0, i=1 gives 4095.
  - No buffer-fill tracking; reads of unwritten words return RAM contents as-is.
- **Reset mid-frame:**
  - Immediate return to reset state; no further ram_wen, mac_* or done.
  - Any sample in flight is lost.
- **Width rules:**
  - Index counter is 13 bits so NTAPW=4096 does not overflow.
  - coef_addr = i[11:0].

Test Plan:
- **Reset values:** reset=0 for 2 cycles -> xin_ready=1; ram_wen, mac_valid, done, busy, overrun all 0; ram_addr=0.
- **Single sample:** NTAPW=4, RD_LAT=3, xin=18'h1ABCD accepted at T ->
  - T+1: ram_wen=1, ram_din=18'h1ABCD.
  - T+2..T+5: ram_addr=0, 4095, 4094, 4093; coef_addr=0..3.
  - T+5..T+8: mac_valid; mac_first@T+5, mac_last@T+8.
  - done@T+9; mac_phase=0.
- **Counter wrap:** feed 16385 samples back-to-back.
  - Sample 16384 (scnt 16383->0): w=0, mac_phase=3.
  - Sample 16385: w=0, mac_phase=0, ram_addr sequence starts at 0.
- **Overrun:** xin_valid held high throughout a frame -> overrun=1 and stays 1; only one ram_wen per frame; the next accept occurs on the done cycle.
- **Boundary NTAPW=1, RD_LAT=1:** accept at T -> ram_wen@T+1, ram_addr@T+2, mac_valid=mac_first=mac_last=1@T+3, done@T+4.
- **Reset mid-frame:** reset=0 at T+4 of an NTAPW=4 frame -> no mac_valid or done afterwards; xin_ready=1 after release; next sample writes with w=0.
